// File: rtl/err_sweep_8x8.sv
// err_sweep_8x8: exhaustive error-characterisation engine for 8x8 approximate
// multipliers. Walks every unsigned (a,b) operand pair, presents it to an
// external multiplier under test, and compares the returned product with the
// exact one. It accumulates error count, error sum and the worst-case error
// together with the first operand pair that produced it.
//
// Build option: define ERR_SQ_EN to add the err_sq_sum port and its
// sum-of-squared-error accumulator.
//
// PROD_LAT (0..4) is the latency of the multiplier under test in cycles.
// A value of 0 means the multiplier is purely combinational.

module err_sweep_8x8 #(
   parameter int PROD_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   input  logic [15:0] mul_prod,
   output logic        busy,
   output logic        done,
   output logic [16:0] err_cnt,
   output logic [31:0] err_sum,
   output logic [15:0] err_max,
   output logic [7:0]  max_a,
   output logic [7:0]  max_b
`ifdef ERR_SQ_EN
   ,
   output logic [47:0] err_sq_sum
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Value of the drain counter on the final DRAIN cycle. It is unused when
   // PROD_LAT is 0, because SWEEP then goes straight to DONE.
   localparam logic [2:0] DRAIN_LAST = 3'((PROD_LAT > 0) ? (PROD_LAT - 1) : 0);

   state_t      state_q, state_d;
   logic [15:0] idx;        // pair currently presented: {a, b}
   logic [2:0]  drn_cnt;    // cycles spent in DRAIN so far
   logic        last_pair;
   logic        clear;

   // Presented operands come straight from the index register, so B is the
   // inner loop.
   assign mul_a = idx[15:8];
   assign mul_b = idx[7:0];

   assign busy      = (state_q == SWEEP) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign last_pair = (idx == 16'hFFFF);
   assign clear     = start && ((state_q == IDLE) || (state_q == DONE));

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always written with non-blocking (<=)
      // assignments, so every register samples the pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic. A start pulse in SWEEP or DRAIN is ignored.
   always_comb begin
      // NOTE: the default assignment comes first so every path assigns
      // state_d, which prevents a latch from being inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SWEEP;
         SWEEP:   if (last_pair) state_d = (PROD_LAT == 0) ? DONE : DRAIN;
         DRAIN:   if (drn_cnt == DRAIN_LAST) state_d = DONE;
         DONE:    if (start) state_d = SWEEP;
         default: state_d = IDLE;
      endcase
   end

   // Pair index and drain counter. The index stops at 65535 and holds (255,255)
   // through DRAIN and DONE, so it never wraps into a second sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         drn_cnt <= '0;
      end else begin
         if (clear)
            idx <= '0;
         else if ((state_q == SWEEP) && !last_pair)
            idx <= idx + 16'd1;

         if (state_q == DRAIN) drn_cnt <= drn_cnt + 3'd1;
         else                  drn_cnt <= '0;
      end
   end

   // Compare-path delay line. The presented register is stage 0. PROD_LAT more
   // stages line each pair up with the product it provokes. tap = {valid, a, b}.
   logic [16:0] tap;
   logic        tap_v;
   logic [7:0]  tap_a, tap_b;

   if (PROD_LAT == 0) begin : g_no_dly
      assign tap = {state_q == SWEEP, mul_a, mul_b};
   end else begin : g_dly
      logic [16:0] dly [PROD_LAT];

      // Shift the presented pair and its valid bit toward the compare point.
      always_ff @(posedge clk) begin
         if (rst) begin
            // NOTE: this small register array is reset explicitly. A stale
            // valid bit left over from an aborted sweep must never reach the
            // accumulators.
            for (int i = 0; i < PROD_LAT; i++) dly[i] <= '0;
         end else begin
            dly[0] <= {state_q == SWEEP, mul_a, mul_b};
            for (int i = 1; i < PROD_LAT; i++) dly[i] <= dly[i-1];
         end
      end

      assign tap = dly[PROD_LAT-1];
   end

   assign tap_v = tap[16];
   assign tap_a = tap[15:8];
   assign tap_b = tap[7:0];

   // Exact product and absolute error. The 17-bit signed difference covers
   // the range -65535..65535, so its magnitude always fits in 16 bits.
   logic [15:0]        exact;
   logic signed [16:0] diff;
   logic [15:0]        abs_d;

   assign exact = 16'(tap_a) * 16'(tap_b);
   assign diff  = $signed({1'b0, exact}) - $signed({1'b0, mul_prod});
   assign abs_d = diff[16] ? 16'(-diff) : diff[15:0];

   // Error accumulators. Strict '>' keeps the first worst pair in sweep order.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_cnt <= '0;
         err_sum <= '0;
         err_max <= '0;
         max_a   <= '0;
         max_b   <= '0;
      end else if (tap_v) begin
         err_cnt <= err_cnt + 17'(abs_d != 16'd0);
         err_sum <= err_sum + 32'(abs_d);
         if (abs_d > err_max) begin
            err_max <= abs_d;
            max_a   <= tap_a;
            max_b   <= tap_b;
         end
      end
   end

`ifdef ERR_SQ_EN
   logic [31:0] sq_d;

   assign sq_d = 32'(abs_d) * 32'(abs_d);

   // Sum of squared errors. It follows the same clear and update rules as
   // err_sum.
   always_ff @(posedge clk) begin
      if (rst || clear)
         err_sq_sum <= '0;
      else if (tap_v)
         err_sq_sum <= err_sq_sum + 48'(sq_d);
   end
`endif

endmodule

// File: tb/tb_err_sweep_8x8.sv
// tb_err_sweep_8x8: directed bench for err_sweep_8x8. Five instances run in
// parallel against different multiplier stubs, so a single sweep's worth of
// cycles covers exact, XOR-1, all-zero and latency-2 products. It also covers
// a reset mid-sweep and start pulses during SWEEP and DONE.

module tb_err_sweep_8x8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic rst_main, rst_r;
   logic start_exact, start_xor, start_zero, start_lat2, start_r;

   // Per-instance signal bundles: exact stub, XOR-1 stub, zero stub,
   // latency-2 exact stub, and an XOR-1 stub used for the reset test.
   logic [7:0]  ex_a, ex_b, xo_a, xo_b, zr_a, zr_b, l2_a, l2_b, rs_a, rs_b;
   logic [15:0] ex_p, xo_p, zr_p, l2_p, rs_p;
   logic        ex_busy, ex_done, xo_busy, xo_done, zr_busy, zr_done;
   logic        l2_busy, l2_done, rs_busy, rs_done;
   logic [16:0] ex_cnt, xo_cnt, zr_cnt, l2_cnt, rs_cnt;
   logic [31:0] ex_sum, xo_sum, zr_sum, l2_sum, rs_sum;
   logic [15:0] ex_max, xo_max, zr_max, l2_max, rs_max;
   logic [7:0]  ex_ma, ex_mb, xo_ma, xo_mb, zr_ma, zr_mb;
   logic [7:0]  l2_ma, l2_mb, rs_ma, rs_mb;
`ifdef ERR_SQ_EN
   logic [47:0] ex_sq, xo_sq, zr_sq, l2_sq, rs_sq;
`endif

   // Multiplier stubs.
   logic [15:0] l2_p1;
   assign ex_p = 16'(ex_a) * 16'(ex_b);
   assign xo_p = (16'(xo_a) * 16'(xo_b)) ^ 16'd1;
   assign zr_p = 16'd0;
   assign rs_p = (16'(rs_a) * 16'(rs_b)) ^ 16'd1;
   always @(posedge clk) begin
      l2_p1 <= 16'(l2_a) * 16'(l2_b);
      l2_p  <= l2_p1;
   end

   err_sweep_8x8 #(.PROD_LAT(0)) u_exact (
      .clk(clk), .rst(rst_main), .start(start_exact), .mul_a(ex_a), .mul_b(ex_b),
      .mul_prod(ex_p), .busy(ex_busy), .done(ex_done), .err_cnt(ex_cnt),
      .err_sum(ex_sum), .err_max(ex_max), .max_a(ex_ma), .max_b(ex_mb)
`ifdef ERR_SQ_EN
      , .err_sq_sum(ex_sq)
`endif
   );

   err_sweep_8x8 #(.PROD_LAT(0)) u_xor (
      .clk(clk), .rst(rst_main), .start(start_xor), .mul_a(xo_a), .mul_b(xo_b),
      .mul_prod(xo_p), .busy(xo_busy), .done(xo_done), .err_cnt(xo_cnt),
      .err_sum(xo_sum), .err_max(xo_max), .max_a(xo_ma), .max_b(xo_mb)
`ifdef ERR_SQ_EN
      , .err_sq_sum(xo_sq)
`endif
   );

   err_sweep_8x8 #(.PROD_LAT(0)) u_zero (
      .clk(clk), .rst(rst_main), .start(start_zero), .mul_a(zr_a), .mul_b(zr_b),
      .mul_prod(zr_p), .busy(zr_busy), .done(zr_done), .err_cnt(zr_cnt),
      .err_sum(zr_sum), .err_max(zr_max), .max_a(zr_ma), .max_b(zr_mb)
`ifdef ERR_SQ_EN
      , .err_sq_sum(zr_sq)
`endif
   );

   err_sweep_8x8 #(.PROD_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst_main), .start(start_lat2), .mul_a(l2_a), .mul_b(l2_b),
      .mul_prod(l2_p), .busy(l2_busy), .done(l2_done), .err_cnt(l2_cnt),
      .err_sum(l2_sum), .err_max(l2_max), .max_a(l2_ma), .max_b(l2_mb)
`ifdef ERR_SQ_EN
      , .err_sq_sum(l2_sq)
`endif
   );

   err_sweep_8x8 #(.PROD_LAT(0)) u_rst (
      .clk(clk), .rst(rst_r), .start(start_r), .mul_a(rs_a), .mul_b(rs_b),
      .mul_prod(rs_p), .busy(rs_busy), .done(rs_done), .err_cnt(rs_cnt),
      .err_sum(rs_sum), .err_max(rs_max), .max_a(rs_ma), .max_b(rs_mb)
`ifdef ERR_SQ_EN
      , .err_sq_sum(rs_sq)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst_main = 1'b1; rst_r = 1'b1;
      start_exact = 1'b0; start_xor = 1'b0; start_zero = 1'b0;
      start_lat2 = 1'b0; start_r = 1'b0;
      tick();
      tick();

      // Reset state.
      check("rst_mul_a",   64'(ex_a),    64'd0);
      check("rst_mul_b",   64'(ex_b),    64'd0);
      check("rst_busy",    64'(ex_busy), 64'd0);
      check("rst_done",    64'(ex_done), 64'd0);
      check("rst_err_cnt", 64'(l2_cnt),  64'd0);
      check("rst_err_max", 64'(l2_max),  64'd0);
      rst_main = 1'b0; rst_r = 1'b0;
      tick();

      // All instances start on the same edge E0.
      start_exact = 1'b1; start_xor = 1'b1; start_zero = 1'b1;
      start_lat2 = 1'b1; start_r = 1'b1;
      tick();
      cyc = 0;
      start_exact = 1'b0; start_xor = 1'b0; start_zero = 1'b0;
      start_lat2 = 1'b0; start_r = 1'b0;
      check("e0_busy",  64'(ex_busy), 64'd1);
      check("e0_done",  64'(ex_done), 64'd0);
      check("e0_pair",  64'({ex_a, ex_b}), 64'd0);
      check("e0_l2busy", 64'(l2_busy), 64'd1);

      // A start pulse mid-SWEEP is ignored: pair 501 = (1,245) follows on.
      while (cyc < 500) tick();
      start_exact = 1'b1;
      tick();
      start_exact = 1'b0;
      check("ign_pair_a", 64'(ex_a),    64'd1);
      check("ign_pair_b", 64'(ex_b),    64'd245);
      check("ign_busy",   64'(ex_busy), 64'd1);

      // Reset 1000 cycles into the sweep clears everything on the next edge.
      while (cyc < 999) tick();
      check("pre_rst_cnt", 64'(rs_cnt), 64'd999);
      rst_r = 1'b1;
      tick();
      rst_r = 1'b0;
      check("mr_mul_a", 64'(rs_a),    64'd0);
      check("mr_mul_b", 64'(rs_b),    64'd0);
      check("mr_busy",  64'(rs_busy), 64'd0);
      check("mr_done",  64'(rs_done), 64'd0);
      check("mr_cnt",   64'(rs_cnt),  64'd0);
      check("mr_sum",   64'(rs_sum),  64'd0);
      check("mr_max",   64'(rs_max),  64'd0);
      check("mr_maxab", 64'({rs_ma, rs_mb}), 64'd0);
`ifdef ERR_SQ_EN
      check("mr_sq",    64'(rs_sq),   64'd0);
`endif
      start_r = 1'b1;
      tick();                         // restart edge = E0+1001
      start_r = 1'b0;
      check("rs_busy", 64'(rs_busy), 64'd1);

      // Completion timing: LAT=0 done after E0+65536, LAT=2 after E0+65538.
      while (cyc < 65535) tick();
      check("ex_done_early", 64'(ex_done), 64'd0);
      check("ex_busy_late",  64'(ex_busy), 64'd1);
      tick();
      check("ex_done_65536", 64'(ex_done), 64'd1);
      check("ex_busy_65536", 64'(ex_busy), 64'd0);
      check("xo_done_65536", 64'(xo_done), 64'd1);
      check("zr_done_65536", 64'(zr_done), 64'd1);
      check("l2_done_65536", 64'(l2_done), 64'd0);
      tick();
      check("l2_busy_65537", 64'(l2_busy), 64'd1);
      check("l2_drain_pair", 64'({l2_a, l2_b}), 64'hFFFF);
      check("l2_done_65537", 64'(l2_done), 64'd0);
      tick();
      check("l2_done_65538", 64'(l2_done), 64'd1);
      check("l2_busy_65538", 64'(l2_busy), 64'd0);

      // Final results.
      check("ex_cnt",   64'(ex_cnt), 64'd0);
      check("ex_sum",   64'(ex_sum), 64'd0);
      check("ex_max",   64'(ex_max), 64'd0);
      check("ex_maxab", 64'({ex_ma, ex_mb}), 64'd0);
      check("xo_cnt",   64'(xo_cnt), 64'd65536);
      check("xo_sum",   64'(xo_sum), 64'd65536);
      check("xo_max",   64'(xo_max), 64'd1);
      check("xo_maxab", 64'({xo_ma, xo_mb}), 64'd0);
      check("zr_cnt",   64'(zr_cnt), 64'd65025);
      check("zr_sum",   64'(zr_sum), 64'd1065369600);
      check("zr_max",   64'(zr_max), 64'd65025);
      check("zr_max_a", 64'(zr_ma),  64'd255);
      check("zr_max_b", 64'(zr_mb),  64'd255);
      check("l2_cnt",   64'(l2_cnt), 64'd0);
      check("l2_sum",   64'(l2_sum), 64'd0);
      check("l2_max",   64'(l2_max), 64'd0);
`ifdef ERR_SQ_EN
      check("xo_sq",    64'(xo_sq),  64'd65536);
      check("zr_sq",    64'(zr_sq),  64'd30910041702400);
      check("ex_sq",    64'(ex_sq),  64'd0);
`endif
      tick();
      check("ex_hold_cnt", 64'(ex_cnt),  64'd0);
      check("xo_hold_cnt", 64'(xo_cnt),  64'd65536);
      check("zr_hold_done", 64'(zr_done), 64'd1);

      // Start in DONE clears results on that edge and begins a new sweep.
      start_xor = 1'b1;
      tick();
      start_xor = 1'b0;
      check("rs2_done",  64'(xo_done), 64'd0);
      check("rs2_busy",  64'(xo_busy), 64'd1);
      check("rs2_pair",  64'({xo_a, xo_b}), 64'd0);
      check("rs2_cnt",   64'(xo_cnt),  64'd0);
      check("rs2_sum",   64'(xo_sum),  64'd0);
      check("rs2_max",   64'(xo_max),  64'd0);
      repeat (100) tick();
      check("rs2_cnt100", 64'(xo_cnt), 64'd100);
      check("rs2_sum100", 64'(xo_sum), 64'd100);
      check("rs2_max100", 64'(xo_max), 64'd1);
      check("rs2_maxab",  64'({xo_ma, xo_mb}), 64'd0);

      // The sweep restarted after reset completes 65536 cycles after its start.
      while (cyc < 66536) tick();
      check("rs_done_early", 64'(rs_done), 64'd0);
      tick();
      check("rs_done", 64'(rs_done), 64'd1);
      check("rs_cnt",  64'(rs_cnt),  64'd65536);
      check("rs_sum",  64'(rs_sum),  64'd65536);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/err_sweep_8x8.md
# err_sweep_8x8

Sequential error-characterisation engine for the 8x8 approximate multipliers. It walks all 65536 unsigned operand pairs and presents each pair to an external multiplier under test. It reads back that multiplier's 16-bit product and compares it against an internally computed exact product. It accumulates error-rate, mean-error and worst-case metrics, and sits beside any 8x8 multiplier instance on the FPGA evaluation board as its stimulus and readback end.

## Interface

- `PROD_LAT`, default 0: clock cycles between `mul_a`/`mul_b` changing and the matching `mul_prod` being valid. Legal range 0..4; 0 means a combinational multiplier.

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to begin a sweep.
- `mul_a` output 8: operand A driven to the multiplier under test (registered).
- `mul_b` output 8: operand B driven to the multiplier under test (registered).
- `mul_prod` input 16: product returned by the multiplier under test.
- `busy` output 1: high in SWEEP and DRAIN.
- `done` output 1: high in DONE; result outputs are valid while it is high.
- `err_cnt` output 17: number of pairs with `mul_prod` ≠ exact product.
- `err_sum` output 32: sum of |exact − `mul_prod`|.
- `err_max` output 16: largest single absolute error.
- `max_a` output 8: A operand of the first pair reaching `err_max`.
- `max_b` output 8: B operand of the first pair reaching `err_max`.
- `err_sq_sum` output 48: sum of squared absolute error. This port exists only with `ERR_SQ_EN`.

## Operation

- States are IDLE, SWEEP, DRAIN and DONE. Reset enters IDLE.
- IDLE or DONE, `start`=1: clear every accumulator and `max_a`/`max_b`, set the pair index to 0, then go to SWEEP. `done` drops on that same edge.
- SWEEP: the 16-bit index i drives `mul_a`=i[15:8] and `mul_b`=i[7:0]. The index increments by 1 each cycle, so B is the inner loop. After i=65535 is presented, go to DRAIN when `PROD_LAT`>0, or directly to DONE when it is 0. The index does not wrap into a second sweep.
- DRAIN: lasts exactly `PROD_LAT` cycles. `mul_a`/`mul_b` hold the last pair (255,255). Then go to DONE.
- DONE: hold all results until the next `start` or `rst`.
- `start` in SWEEP or DRAIN is ignored.
- Compare path:
  - A delay line of depth `PROD_LAT`+1 carries the presented operands and a valid bit.
  - At the edge where a delayed valid pair is present, compute exact = a·b (16-bit, unsigned).
  - Compute d = |exact − `mul_prod`| from a 17-bit signed difference. The result always fits in 16 bits.
- Accumulation, on the same edge:
  - `err_cnt` += (d≠0).
  - `err_sum` += d.
  - If d > `err_max`, update `err_max`, `max_a` and `max_b`. The comparison is strict, so the first occurrence in sweep order wins.
  - Every sum has headroom for 65536 worst-case terms, so there is no saturation.
- `rst` at any time, including mid-sweep, returns to IDLE. It zeroes all outputs and the delay line, and discards partial results.

## Timing

- Reset value of every output is 0, including `mul_a`, `mul_b`, `busy` and `done`.
- `start` sampled at edge E0: after E0, `busy`=1 and pair 0 is on `mul_a`/`mul_b`.
- Pair n is presented after edge E0+n and accumulated at edge E0+n+`PROD_LAT`+1.
- After edge E0+65536+`PROD_LAT`, `done`=1, `busy`=0, and the final results are stable.
- Sweep length is therefore 65536+`PROD_LAT` cycles from the start edge to `done`.
- `mul_prod` is sampled only at accumulation edges. Its value at any other time is don't-care.

## Configuration

- `ERR_SQ_EN` defined:
  - Adds the `err_sq_sum` port and a 48-bit accumulator of d² (16x16 multiply).
  - The accumulator is cleared and updated with the same rules and timing as `err_sum`.
- `ERR_SQ_EN` undefined:
  - The port and the squaring logic are absent.
  - All other behaviour and timing are identical.

## Test plan

- Exact stub (`mul_prod`=a·b), `PROD_LAT`=0, pulse `start`:
  - `err_cnt`=0, `err_sum`=0, `err_max`=0, `max_a`=`max_b`=0.
  - `done` rises exactly 65536 cycles after the start edge.
- Stub `mul_prod`=a·b XOR 1:
  - `err_cnt`=65536, `err_sum`=65536, `err_max`=1, (`max_a`,`max_b`)=(0,0).
  - With `ERR_SQ_EN`: `err_sq_sum`=65536.
- Stub `mul_prod`=0:
  - `err_cnt`=65025, `err_sum`=1065369600, `err_max`=65025, (`max_a`,`max_b`)=(255,255).
- `PROD_LAT`=2 with a two-register exact stub:
  - All error outputs are 0.
  - `done` rises 65538 cycles after the start edge.
  - `busy` is high for exactly 65538 cycles.
- Assert `rst` 1000 cycles into a sweep:
  - Next cycle: all outputs are 0 and the block is in IDLE.
  - A fresh `start` with the XOR-1 stub gives `err_cnt`=65536.
- Pulse `start` mid-SWEEP: ignored, and the completion cycle is unchanged.
- Pulse `start` in DONE: results clear on that edge and a new sweep with identical results follows.
